pipelined_ripple_subtractor: RTL

Multi-beat subtractor computing D = A − B − bin over operands presented as a sequence of WIDTH-bit beats, least-significant beat first, with a borrow chained between beats of one frame. Input and output are each registered, mirroring the team's pipelined ripple adder, and both ends use a valid/ready handshake. The block sits beside the adder in the arithmetic datapath and supplies the subtract direction, for example to undo an accumulated sum.

---
 rtl/pipelined_ripple_subtractor_pkg.sv | 22 ++
 rtl/pipelined_ripple_subtractor_if.sv | 39 +++
 rtl/pipelined_ripple_subtractor_ripple.sv | 27 ++
 rtl/pipelined_ripple_subtractor.sv | 93 +++++++++
 4 files changed

// File: rtl/pipelined_ripple_subtractor_pkg.sv
// Shared arithmetic package: beat width plus the S1 beat and S2 result payloads.
package arith_pkg;

  localparam int unsigned WIDTH = 4;

  // One input beat as captured in S1.
  typedef struct packed {
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             first;
    logic             last;
    logic             bin;
  } beat_t;

  // One difference beat as held in S2.
  typedef struct packed {
    logic [WIDTH-1:0] D;
    logic             bout;
    logic             last;
  } result_t;

endpackage

// File: rtl/pipelined_ripple_subtractor_if.sv
// Beat stream interface of the pipelined ripple subtractor.
// The ovf signal exists only when PIPELINED_RIPPLE_SUB_OVF_EN is defined.
interface pipelined_ripple_subtractor_if;

  logic [arith_pkg::WIDTH-1:0] A;
  logic [arith_pkg::WIDTH-1:0] B;
  logic                        bin;
  logic                        in_first;
  logic                        in_last;
  logic                        in_valid;
  logic                        in_ready;
  logic [arith_pkg::WIDTH-1:0] D;
  logic                        bout;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;
`ifdef PIPELINED_RIPPLE_SUB_OVF_EN
  logic                        ovf;
`endif

  // Producer of operand beats and consumer of difference beats.
  modport master (
    output A, B, bin, in_first, in_last, in_valid, out_ready,
    input  in_ready, D, bout, out_last, out_valid
`ifdef PIPELINED_RIPPLE_SUB_OVF_EN
    , input ovf
`endif
  );

  // The subtractor itself.
  modport slave (
    input  A, B, bin, in_first, in_last, in_valid, out_ready,
    output in_ready, D, bout, out_last, out_valid
`ifdef PIPELINED_RIPPLE_SUB_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/pipelined_ripple_subtractor_ripple.sv
// Combinational WIDTH-bit ripple chain of full subtractors: {bout, D} = A - B - bin.
module ripple_subtractor #(
  parameter int unsigned WIDTH = arith_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             bout
);

  logic [WIDTH:0] br;

  // Bit-serial borrow ripple, LSB first.
  always_comb begin
    br    = '0;
    D     = '0;
    br[0] = bin;
    for (int i = 0; i < WIDTH; i++) begin
      D[i]    = A[i] ^ B[i] ^ br[i];
      br[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & br[i]);
    end
  end

  assign bout = br[WIDTH];

endmodule

// File: rtl/pipelined_ripple_subtractor.sv
// Two-stage multi-beat subtractor D = A - B - bin, LSB beat first, borrow
// chained between beats of a frame. S1 registers the input beat, S2 the result.
// Optional: PIPELINED_RIPPLE_SUB_OVF_EN adds the frame signed-overflow flag ovf.
module pipelined_ripple_subtractor
  import arith_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  pipelined_ripple_subtractor_if.slave  io
);

  beat_t            s1_q;
  logic             s1_valid_q;
  result_t          s2_q;
  logic             s2_valid_q;
  logic             brw_q;

  logic             s1_move_c;
  logic             in_xfer_c;
  logic             borrow_in_c;
  logic [WIDTH-1:0] d_c;
  logic             bout_c;

  // S1 drains into S2 when S2 is empty or is being consumed this cycle.
  assign s1_move_c   = s1_valid_q && (!s2_valid_q || io.out_ready);
  assign io.in_ready = !s1_valid_q || s1_move_c;
  assign in_xfer_c   = io.in_valid && io.in_ready;

  // A first beat starts a fresh chain from its own bin; later beats use brw.
  assign borrow_in_c = s1_q.first ? s1_q.bin : brw_q;

  ripple_subtractor #(.WIDTH(WIDTH)) u_sub (
    .A    (s1_q.A),
    .B    (s1_q.B),
    .bin  (borrow_in_c),
    .D    (d_c),
    .bout (bout_c)
  );

  // S1 input register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (in_xfer_c) begin
      s1_valid_q <= 1'b1;
      s1_q       <= '{A: io.A, B: io.B, first: io.in_first, last: io.in_last, bin: io.bin};
    end else if (s1_move_c) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2 output register and inter-beat borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      brw_q      <= 1'b0;
    end else if (s1_move_c) begin
      s2_valid_q <= 1'b1;
      s2_q       <= '{D: d_c, bout: bout_c, last: s1_q.last};
      brw_q      <= bout_c;
    end else if (s2_valid_q && io.out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign io.D         = s2_q.D;
  assign io.bout      = s2_q.bout;
  assign io.out_last  = s2_q.last;
  assign io.out_valid = s2_valid_q;

`ifdef PIPELINED_RIPPLE_SUB_OVF_EN
  logic ovf_c;
  logic s2_ovf_q;

  // Signed overflow judged on the MSBs of the last beat only.
  assign ovf_c = s1_q.last && (s1_q.A[WIDTH-1] != s1_q.B[WIDTH-1])
                           && (d_c[WIDTH-1] != s1_q.A[WIDTH-1]);

  // ovf travels with its S2 beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_ovf_q <= 1'b0;
    end else if (s1_move_c) begin
      s2_ovf_q <= ovf_c;
    end
  end

  assign io.ovf = s2_ovf_q;
`endif

endmodule
